stp_word_collector: RTL and testbench
=====================================

# stp_word_collector

Downstream companion of the serial-to-parallel shift register. It counts the shift strobes that drive that register. When a full word has been shifted in, it captures the register's parallel output into a 2-entry output buffer, which it presents to the consumer over a valid/ready handshake. It also reports an overrun when the buffer cannot accept a completed word.

## Interface
Parameters:
- NUM_BITS, 8, word width; equals the shift register width; legal range 2..32
- FIFO_DEPTH, 2, output buffer entries; fixed, not overridable in this revision

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- frame_start  in  1  synchronous pulse: starts a new word and clears the bit count
- shift_enable  in  1  the same strobe that drives the shift register; one bit per high cycle
- parallel_in  in  NUM_BITS  shift register parallel output
- word_ready  in  1  consumer accepts word_out this cycle
- clear_overrun  in  1  clears the sticky overrun flag
- word_out  out  NUM_BITS  head of buffer
- word_valid  out  1  buffer not empty
- overrun  out  1  sticky: a completed word was dropped
- bit_count  out  $clog2(NUM_BITS+1)  bits shifted in the current word
- busy  out  1  FSM not in IDLE

## Operation
- FSM states, typedef collector_state_t:
  - IDLE: shift_enable is ignored; frame_start enters COUNT.
  - COUNT: each shift_enable increments bit_count. A strobe with bit_count == NUM_BITS-1 goes to CAPTURE and resets bit_count to 0.
  - CAPTURE: exactly one cycle. parallel_in is written to the buffer, then the FSM returns to COUNT. Capture waits one cycle because the shift register's output reflects the last bit one cycle after the strobe.
- frame_start in COUNT: bit_count := 0.
  - With a simultaneous shift_enable, that bit is bit 0, so bit_count := 1.
- frame_start in CAPTURE: the capture still completes; the count restarts as above.
- shift_enable in CAPTURE: counted as bit 0 of the next word (bit_count := 1).
- Buffer write in CAPTURE is accepted if not full, or if full with word_valid && word_ready in the same cycle (pop first, then push).
  - Otherwise the word is dropped and overrun := 1.
- overrun clears only via clear_overrun.
  - If clear_overrun and a new drop occur in the same cycle, overrun stays 1.
- Pop occurs when word_valid && word_ready; word_ready with empty buffer has no effect.
- Buffer ordering is FIFO; word_out is the oldest word.

## Timing
- Reset values: state IDLE, word_out 0, word_valid 0, overrun 0, bit_count 0, busy 0, buffer empty.
- Reset mid-operation: a partial word and all buffered words are discarded.
- Latency from the final shift_enable to word_valid, with the buffer empty:
  - strobe in cycle N;
  - CAPTURE in cycle N+1;
  - word_valid high from cycle N+2.
- Minimum legal shift_enable spacing is 1 cycle; back-to-back words sustain full rate.
- word_out is registered and stable while word_valid && !word_ready.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package stp_pkg holds:
  - collector_state_t enum {IDLE, COUNT, CAPTURE};
  - localparam FIFO_DEPTH = 2.
- Sub-module word_fifo2: 2-entry register FIFO, parameterized by NUM_BITS.
  - Ports: push, pop, din, dout, empty, full.
  - Same-cycle push and pop when full are legal.
- The top level contains the FSM, bit counter and overrun logic.

## Test plan
- Basic word, NUM_BITS=8: reset, frame_start, then 8 consecutive shift_enable with parallel_in = 8'hA5 at CAPTURE, word_ready held 1 -> word_out=8'hA5 and word_valid=1 two cycles after the 8th strobe, high for one cycle.
- Fill and overrun: word_ready=0, three complete words 8'h11, 8'h22, 8'h33 -> buffer holds 8'h11, 8'h22 and overrun=1. Raising word_ready then pops 11 then 22, and word_valid falls. clear_overrun -> overrun=0.
- Full with simultaneous pop: buffer holds 11, 22; word_ready=1 in the CAPTURE cycle of 8'h33 -> no overrun; subsequent pops give 22 then 33.
- Mid-word frame_start: 5 strobes, then frame_start with shift_enable -> bit_count=1. The word completes after 7 more strobes, not 3.
- Shifts ignored in IDLE: 10 strobes before any frame_start -> bit_count=0, word_valid=0.
- Async reset mid-word: assert rst between clock edges at bit_count=4 with one buffered word -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stp_pkg.sv
// Shared types and constants for the serial-to-parallel word collector.
package stp_pkg;

    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        CAPTURE = 2'd2
    } collector_state_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head so dout is a flop.
module word_fifo2
    import stp_pkg::*;
#(
    parameter int unsigned NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [NUM_BITS-1:0] din,
    output logic [NUM_BITS-1:0] dout,
    output logic                empty,
    output logic                full
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_BITS-1:0] mem0_q, mem0_d;
    logic [NUM_BITS-1:0] mem1_q, mem1_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                empty_q, full_q;
    logic                do_pop, do_push;

    // Pop shifts entry 1 into the head; push then lands in the first free slot.
    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        cnt_d   = cnt_q;
        do_pop  = pop && !empty_q;
        do_push = push && (!full_q || do_pop);
        if (do_pop) begin
            mem0_d = mem1_q;
            cnt_d  = cnt_q - CNT_W'(1);
        end
        if (do_push) begin
            if (cnt_d == CNT_W'(0)) begin
                mem0_d = din;
            end else begin
                mem1_d = din;
            end
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    // Storage and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == CNT_W'(0));
            full_q  <= (cnt_d == CNT_W'(FIFO_DEPTH));
        end
    end

    assign dout  = mem0_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/stp_word_collector.sv
// Counts shift strobes, captures each completed word into a 2-entry buffer
// one cycle after its last strobe, and flags words dropped on a full buffer.
module stp_word_collector
    import stp_pkg::*;
#(
    parameter int unsigned NUM_BITS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_start,
    input  logic                            shift_enable,
    input  logic [NUM_BITS-1:0]             parallel_in,
    input  logic                            word_ready,
    input  logic                            clear_overrun,
    output logic [NUM_BITS-1:0]             word_out,
    output logic                            word_valid,
    output logic                            overrun,
    output logic [$clog2(NUM_BITS+1)-1:0]   bit_count,
    output logic                            busy
);

    localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

    collector_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             busy_q;
    logic             push;
    logic             drop;
    logic             fifo_empty, fifo_full;

    // Next state, bit count and overrun; CAPTURE writes the buffer for one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                if (frame_start) begin
                    cnt_d = shift_enable ? CNT_W'(1) : CNT_W'(0);
                end else if (shift_enable) begin
                    if (cnt_q == CNT_W'(NUM_BITS - 1)) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CAPTURE: begin
                push    = 1'b1;
                state_d = COUNT;
                cnt_d   = shift_enable ? CNT_W'(1) : CNT_W'(0);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        drop      = push && fifo_full && !(word_valid && word_ready);
        overrun_d = drop ? 1'b1 : (clear_overrun ? 1'b0 : overrun_q);
    end

    // State, counter and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    word_fifo2 #(
        .NUM_BITS (NUM_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (word_ready),
        .din   (parallel_in),
        .dout  (word_out),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign word_valid = !fifo_empty;
    assign overrun    = overrun_q;
    assign bit_count  = cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_stp_word_collector.sv
// Scoreboard bench for stp_word_collector with NUM_BITS = 8.
module tb_stp_word_collector;

    localparam int unsigned NB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          shift_enable;
    logic [NB-1:0] parallel_in;
    logic          word_ready;
    logic          clear_overrun;
    logic [NB-1:0] word_out;
    logic          word_valid;
    logic          overrun;
    logic [3:0]    bit_count;
    logic          busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [NB-1:0] exp_q[$];

    stp_word_collector #(.NUM_BITS(NB)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .shift_enable  (shift_enable),
        .parallel_in   (parallel_in),
        .word_ready    (word_ready),
        .clear_overrun (clear_overrun),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .overrun       (overrun),
        .bit_count     (bit_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Eight strobes, then the capture cycle where parallel_in holds the word.
    task automatic send_word(input logic [NB-1:0] d, input logic rdy_cap,
                             input logic se_cap, input logic chk_lat);
        logic saved_rdy;
        for (int i = 0; i < 8; i++) begin
            shift_enable = 1'b1;
            parallel_in  = ~d;
            tick();
        end
        saved_rdy    = word_ready;
        shift_enable = se_cap;
        parallel_in  = d;
        if (rdy_cap) word_ready = 1'b1;
        if (chk_lat) chk("valid_low_in_capture", 32'(word_valid), 32'd0);
        tick();
        word_ready   = saved_rdy;
        shift_enable = 1'b0;
        parallel_in  = '0;
    endtask

    // Monitor: every handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        if (!rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", word_out);
            end else begin
                chk("word_out", 32'(word_out), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; frame_start = 1'b0; shift_enable = 1'b0; parallel_in = '0;
        word_ready = 1'b0; clear_overrun = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_word_out", 32'(word_out), 32'd0);
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Strobes in IDLE are ignored.
        shift_enable = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        shift_enable = 1'b0;
        chk("idle_bit_count", 32'(bit_count), 32'd0);
        chk("idle_valid", 32'(word_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Basic word with consumer always ready.
        word_ready  = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("busy_after_frame", 32'(busy), 32'd1);
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 1'b0, 1'b0, 1'b1);
        chk("basic_valid_n2", 32'(word_valid), 32'd1);
        tick();
        chk("basic_valid_one_cycle", 32'(word_valid), 32'd0);

        // Fill the buffer with the consumer stalled; third word is dropped.
        word_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        chk("fill_no_overrun_yet", 32'(overrun), 32'd0);
        send_word(8'h33, 1'b0, 1'b0, 1'b0);
        chk("fill_overrun", 32'(overrun), 32'd1);
        chk("fill_head", 32'(word_out), 32'h11);
        word_ready = 1'b1;
        tick(); tick();
        chk("fill_drained", 32'(word_valid), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        word_ready    = 1'b0;
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);

        // Full buffer with a pop in the capture cycle accepts the new word.
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        send_word(8'h33, 1'b1, 1'b0, 1'b0);
        chk("pop_push_no_overrun", 32'(overrun), 32'd0);
        chk("pop_push_head", 32'(word_out), 32'h22);
        word_ready = 1'b1;
        tick(); tick();
        chk("pop_push_drained", 32'(word_valid), 32'd0);

        // frame_start with a strobe mid-word restarts the count at 1.
        shift_enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_count5", 32'(bit_count), 32'd5);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("mid_restart", 32'(bit_count), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("mid_no_early_capture", 32'(bit_count), 32'd4);
        for (int i = 0; i < 3; i++) tick();
        chk("mid_count7", 32'(bit_count), 32'd7);
        exp_q.push_back(8'h5C);
        tick();
        shift_enable = 1'b0;
        parallel_in  = 8'h5C;
        tick();
        parallel_in  = '0;
        chk("mid_word_valid", 32'(word_valid), 32'd1);
        tick();

        // Strobe during CAPTURE is bit 0 of the next word; then async reset.
        word_ready = 1'b0;
        exp_q.push_back(8'h77);
        send_word(8'h77, 1'b0, 1'b1, 1'b0);
        chk("capture_strobe_count", 32'(bit_count), 32'd1);
        shift_enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        shift_enable = 1'b0;
        chk("pre_reset_count", 32'(bit_count), 32'd4);
        chk("pre_reset_valid", 32'(word_valid), 32'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_word_out", 32'(word_out), 32'd0);
        chk("async_valid", 32'(word_valid), 32'd0);
        chk("async_bit_count", 32'(bit_count), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_overrun", 32'(overrun), 32'd0);
        tick();
        rst = 1'b0;
        shift_enable = 1'b1;
        tick(); tick();
        shift_enable = 1'b0;
        chk("post_reset_idle", 32'(bit_count), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
